// File: rtl/seq_code_checker_if.sv
// Bundle between the cyclic code counter, the checker and the status/display logic.
// The master side drives the code stream; the slave side is the checker.
interface seq_code_checker_if #(parameter int LAP_W = 8);
    logic [2:0]       code_in;
    logic             code_valid;
    logic             clear;
    logic [2:0]       index;
    logic             index_valid;
    logic             locked;
    logic [1:0]       state;
    logic             seq_err;
    logic [7:0]       err_count;
    logic             lap_tick;
    logic [LAP_W-1:0] lap_count;

    modport master (
        output code_in, code_valid, clear,
        input  index, index_valid, locked, state, seq_err, err_count, lap_tick, lap_count
    );
    modport slave (
        input  code_in, code_valid, clear,
        output index, index_valid, locked, state, seq_err, err_count, lap_tick, lap_count
    );
endinterface

// File: rtl/seq_code_checker.sv
// Monitor for the 3-bit cyclic code 000->100->111->010->011: locks onto the sequence,
// decodes ordinals, flags out-of-sequence codes and counts completed laps.
module seq_code_checker #(
    parameter int LAP_W     = 8,
    parameter int SYNC_LEN  = 2,
    parameter int ERR_LIMIT = 3
) (
    input logic               clk,
    input logic               reset,
    seq_code_checker_if.slave bus
);
    typedef enum logic [1:0] {HUNT = 2'b00, SYNC = 2'b01, LOCK = 2'b10} state_t;

    localparam logic [3:0] SYNC_N = 4'(SYNC_LEN);
    localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

    function automatic logic [2:0] next_code(input logic [2:0] c);
        case (c)
            3'b000:  next_code = 3'b100;
            3'b100:  next_code = 3'b111;
            3'b111:  next_code = 3'b010;
            3'b010:  next_code = 3'b011;
            default: next_code = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] ordinal(input logic [2:0] c);
        case (c)
            3'b000:  ordinal = 3'd0;
            3'b100:  ordinal = 3'd1;
            3'b111:  ordinal = 3'd2;
            3'b010:  ordinal = 3'd3;
            3'b011:  ordinal = 3'd4;
            default: ordinal = 3'd7;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       match_q, match_d;
    logic [2:0]       miss_q, miss_d;
    logic [2:0]       index_q;
    logic             index_valid_q, seq_err_q, lap_tick_q;
    logic             seq_err_d, lap_tick_d;
    logic [7:0]       err_count_q;
    logic [LAP_W-1:0] lap_count_q;
    logic             legal;
    logic [3:0]       match_inc, miss_inc;

    assign legal     = (ordinal(bus.code_in) != 3'd7);
    assign match_inc = {1'b0, match_q} + 4'd1;
    assign miss_inc  = {1'b0, miss_q} + 4'd1;

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        match_d    = match_q;
        miss_d     = miss_q;
        seq_err_d  = 1'b0;
        lap_tick_d = 1'b0;
        case (state_q)
            HUNT: if (bus.code_valid && legal) begin
                exp_d   = next_code(bus.code_in);
                match_d = 3'd1;
                miss_d  = 3'd0;
                state_d = (SYNC_N == 4'd1) ? LOCK : SYNC;
            end
            SYNC: if (bus.code_valid) begin
                if (!legal) begin
                    state_d = HUNT;
                    match_d = 3'd0;
                end else if (bus.code_in == exp_q) begin
                    match_d = match_inc[2:0];
                    exp_d   = next_code(bus.code_in);
                    if (match_inc >= SYNC_N) begin
                        state_d = LOCK;
                        miss_d  = 3'd0;
                    end
                end else begin
                    match_d = 3'd1;
                    exp_d   = next_code(bus.code_in);
                end
            end
            LOCK: if (bus.code_valid) begin
                // Flywheel: expected advances on every sample, hit or miss.
                exp_d = next_code(exp_q);
                if (bus.code_in == exp_q) begin
                    miss_d     = 3'd0;
                    lap_tick_d = (bus.code_in == 3'b000);
                end else begin
                    seq_err_d = 1'b1;
                    miss_d    = miss_inc[2:0];
                    if (miss_inc >= ERR_N) begin
                        state_d = HUNT;
                        match_d = 3'd0;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            exp_q         <= 3'b000;
            match_q       <= 3'd0;
            miss_q        <= 3'd0;
            index_q       <= 3'd0;
            index_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
            lap_tick_q    <= 1'b0;
            err_count_q   <= 8'd0;
            lap_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            index_valid_q <= bus.code_valid;
            seq_err_q     <= seq_err_d;
            lap_tick_q    <= lap_tick_d;
            if (bus.code_valid) index_q <= ordinal(bus.code_in);
            if (bus.clear)                           err_count_q <= 8'd0;
            else if (seq_err_d && err_count_q != 8'hff) err_count_q <= err_count_q + 8'd1;
            if (bus.clear)           lap_count_q <= '0;
            else if (lap_tick_d)     lap_count_q <= lap_count_q + 1'b1;
        end
    end

    assign bus.index       = index_q;
    assign bus.index_valid = index_valid_q;
    assign bus.locked      = (state_q == LOCK);
    assign bus.state       = state_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.err_count   = err_count_q;
    assign bus.lap_tick    = lap_tick_q;
    assign bus.lap_count   = lap_count_q;
endmodule

// File: tb/tb_seq_code_checker.sv
// Directed bench for seq_code_checker (SYNC_LEN=2, ERR_LIMIT=3, LAP_W=8).
module tb_seq_code_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_code_checker_if #(.LAP_W(8)) bus();

    seq_code_checker #(.LAP_W(8), .SYNC_LEN(2), .ERR_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] c, input logic v, input logic clr);
        @(negedge clk);
        bus.code_in    = c;
        bus.code_valid = v;
        bus.clear      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".index"}, 32'(bus.index), 0);
        chk({tag, ".index_valid"}, 32'(bus.index_valid), 0);
        chk({tag, ".locked"}, 32'(bus.locked), 0);
        chk({tag, ".state"}, 32'(bus.state), 0);
        chk({tag, ".seq_err"}, 32'(bus.seq_err), 0);
        chk({tag, ".err_count"}, 32'(bus.err_count), 0);
        chk({tag, ".lap_tick"}, 32'(bus.lap_tick), 0);
        chk({tag, ".lap_count"}, 32'(bus.lap_count), 0);
    endtask

    initial begin
        logic [2:0] lap_codes [5];
        logic [2:0] idx_exp [5];
        lap_codes = '{3'b000, 3'b100, 3'b111, 3'b010, 3'b011};
        idx_exp   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        bus.code_in = 3'b000; bus.code_valid = 1'b0; bus.clear = 1'b0;

        // 1: reset and one clean lap
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(lap_codes[i], 1'b1, 1'b0);
            chk("t1.index", 32'(bus.index), 32'(idx_exp[i]));
            chk("t1.index_valid", 32'(bus.index_valid), 1);
            chk("t1.locked", 32'(bus.locked), (i >= 1) ? 1 : 0);
            chk("t1.seq_err", 32'(bus.seq_err), 0);
            chk("t1.lap_tick", 32'(bus.lap_tick), 0);
        end
        step(3'b000, 1'b1, 1'b0);
        chk("t1.index_last", 32'(bus.index), 0);
        chk("t1.lap_tick", 32'(bus.lap_tick), 1);
        chk("t1.lap_count", 32'(bus.lap_count), 1);
        chk("t1.seq_err_last", 32'(bus.seq_err), 0);
        step(3'b000, 1'b0, 1'b0);
        chk("t1.lap_tick_once", 32'(bus.lap_tick), 0);
        chk("t1.index_valid_gap", 32'(bus.index_valid), 0);

        // 2: single error with flywheel recovery
        step(3'b100, 1'b1, 1'b0);
        step(3'b111, 1'b1, 1'b0);
        step(3'b111, 1'b1, 1'b0);
        chk("t2.seq_err", 32'(bus.seq_err), 1);
        chk("t2.err_count", 32'(bus.err_count), 1);
        chk("t2.locked", 32'(bus.locked), 1);
        step(3'b011, 1'b1, 1'b0);
        chk("t2.seq_err_fly", 32'(bus.seq_err), 0);
        chk("t2.err_count_fly", 32'(bus.err_count), 1);
        chk("t2.index_fly", 32'(bus.index), 4);

        // 3: three illegal codes drop lock
        step(3'b000, 1'b0, 1'b1);
        chk("t3.clear_err", 32'(bus.err_count), 0);
        chk("t3.clear_lap", 32'(bus.lap_count), 0);
        for (int i = 1; i <= 3; i++) begin
            step(3'b101, 1'b1, 1'b0);
            chk("t3.seq_err", 32'(bus.seq_err), 1);
            chk("t3.index", 32'(bus.index), 7);
            chk("t3.err_count", 32'(bus.err_count), 32'(i));
            chk("t3.locked", 32'(bus.locked), (i < 3) ? 1 : 0);
        end
        chk("t3.state", 32'(bus.state), 0);

        // 4: reacquire with gaps
        step(3'b110, 1'b1, 1'b0);
        chk("t4.hunt_hold", 32'(bus.state), 0);
        chk("t4.index_illegal", 32'(bus.index), 7);
        step(3'b000, 1'b0, 1'b0);
        chk("t4.gap_state", 32'(bus.state), 0);
        chk("t4.gap_index", 32'(bus.index), 7);
        chk("t4.gap_valid", 32'(bus.index_valid), 0);
        step(3'b111, 1'b1, 1'b0);
        chk("t4.sync", 32'(bus.state), 1);
        chk("t4.index", 32'(bus.index), 2);
        step(3'b101, 1'b0, 1'b0);
        chk("t4.gap2_state", 32'(bus.state), 1);
        chk("t4.gap2_index", 32'(bus.index), 2);
        chk("t4.gap2_seq_err", 32'(bus.seq_err), 0);
        step(3'b010, 1'b1, 1'b0);
        chk("t4.lock", 32'(bus.state), 2);
        chk("t4.locked", 32'(bus.locked), 1);
        chk("t4.lap_tick", 32'(bus.lap_tick), 0);

        // 5: 300 laps, 130 two-error bursts
        step(3'b000, 1'b0, 1'b1);
        step(3'b011, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(3'b000, 1'b1, 1'b0);
            if (i == 255) chk("t5.lap_wrap", 32'(bus.lap_count), 0);
            if (i < 130) begin
                step(3'b101, 1'b1, 1'b0);
                step(3'b101, 1'b1, 1'b0);
            end else begin
                step(3'b100, 1'b1, 1'b0);
                step(3'b111, 1'b1, 1'b0);
            end
            step(3'b010, 1'b1, 1'b0);
            step(3'b011, 1'b1, 1'b0);
        end
        chk("t5.lap_count", 32'(bus.lap_count), 44);
        chk("t5.err_sat", 32'(bus.err_count), 255);
        chk("t5.locked", 32'(bus.locked), 1);
        step(3'b000, 1'b1, 1'b1);
        chk("t5.clr_tick", 32'(bus.lap_tick), 1);
        chk("t5.clr_lap", 32'(bus.lap_count), 0);
        chk("t5.clr_err", 32'(bus.err_count), 0);

        // 6: asynchronous reset mid-lap
        step(3'b100, 1'b1, 1'b0);
        chk("t6.pre_locked", 32'(bus.locked), 1);
        @(negedge clk);
        bus.code_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_zero("t6.async");
        @(negedge clk) reset = 1'b0;
        step(3'b011, 1'b1, 1'b0);
        chk("t6.sync", 32'(bus.state), 1);
        chk("t6.index", 32'(bus.index), 4);
        step(3'b000, 1'b1, 1'b0);
        chk("t6.lock", 32'(bus.state), 2);
        chk("t6.no_tick", 32'(bus.lap_tick), 0);
        chk("t6.lap_count", 32'(bus.lap_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
